// File: rtl/div_sequencer_if.sv
// Bundle between div_sequencer and its surroundings: the EX-stage request/result
// side and the iterative-divider handshake side. The sequencer uses modport slave.
interface div_sequencer_if;
    localparam int unsigned XLEN = 64;

    logic            req_valid_i;
    logic [2:0]      req_op_i;
    logic [XLEN-1:0] srcA_i;
    logic [XLEN-1:0] srcB_i;
    logic            flush_i;
    logic            stall_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;

    logic            div_start_o;
    logic            div_signed_o;
    logic [XLEN-1:0] div_a_o;
    logic [XLEN-1:0] div_b_o;
    logic            div_ready_i;
    logic [XLEN-1:0] div_q_i;
    logic [XLEN-1:0] div_r_i;

    modport master (
        output req_valid_i, req_op_i, srcA_i, srcB_i, flush_i,
        input  stall_o, result_valid_o, result_o,
        input  div_start_o, div_signed_o, div_a_o, div_b_o,
        output div_ready_i, div_q_i, div_r_i
    );

    modport slave (
        input  req_valid_i, req_op_i, srcA_i, srcB_i, flush_i,
        output stall_o, result_valid_o, result_o,
        output div_start_o, div_signed_o, div_a_o, div_b_o,
        input  div_ready_i, div_q_i, div_r_i
    );
endinterface

// File: rtl/div_sequencer.sv
// Sequences DIV/REM ops from EX onto a multi-cycle divider and returns width-adjusted results.
// Optional macro DIV_FASTPATH_EN resolves divide-by-zero and signed overflow in IDLE.
module div_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_op_rem;
    logic            r_op_word;
    logic            r_div_start;
    logic            r_div_signed;
    logic [XLEN-1:0] r_div_a;
    logic [XLEN-1:0] r_div_b;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_stall_c;
    logic            w_result_valid_c;
    logic [XLEN-1:0] w_prep_a;
    logic [XLEN-1:0] w_prep_b;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;

    // W results are always the sign-extended low word, signed or unsigned alike
    function automatic logic [XLEN-1:0] fit_width(input logic word, input logic [XLEN-1:0] v);
        return word ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
    endfunction

    // W ops narrow operands to 32 bits: sign-extend for signed, zero-extend for unsigned
    always_comb begin
        w_prep_a = bus.srcA_i;
        w_prep_b = bus.srcB_i;
        if (bus.req_op_i[2]) begin
            if (bus.req_op_i[1]) begin
                w_prep_a = {{(XLEN-WLEN){1'b0}}, bus.srcA_i[WLEN-1:0]};
                w_prep_b = {{(XLEN-WLEN){1'b0}}, bus.srcB_i[WLEN-1:0]};
            end else begin
                w_prep_a = {{(XLEN-WLEN){bus.srcA_i[WLEN-1]}}, bus.srcA_i[WLEN-1:0]};
                w_prep_b = {{(XLEN-WLEN){bus.srcB_i[WLEN-1]}}, bus.srcB_i[WLEN-1:0]};
            end
        end
    end

`ifdef DIV_FASTPATH_EN
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WLEN-1:0] MIN_NEGW = {1'b1, {(WLEN-1){1'b0}}};

    logic w_div_zero;
    logic w_overflow;

    // Special cases are judged on the prepared operands
    always_comb begin
        w_div_zero = (w_prep_b == '0);
        w_overflow = 1'b0;
        if (!bus.req_op_i[1]) begin
            if (bus.req_op_i[2]) begin
                w_overflow = (w_prep_a[WLEN-1:0] == MIN_NEGW) && (w_prep_b[WLEN-1:0] == '1);
            end else begin
                w_overflow = (w_prep_a == MIN_NEG) && (w_prep_b == '1);
            end
        end
        w_fast     = w_div_zero | w_overflow;
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = fit_width(bus.req_op_i[2], bus.req_op_i[0] ? w_prep_a : '1);
        end else if (w_overflow) begin
            w_fast_res = fit_width(bus.req_op_i[2], bus.req_op_i[0] ? '0 : w_prep_a);
        end
    end
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    assign w_accept = bus.req_valid_i & ~bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_stall_c        = 1'b0;
        w_result_valid_c = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall_c = 1'b1;
                    w_next    = w_fast ? S_DONE : S_START;
                end
            end
            S_START: begin
                w_stall_c = 1'b1;
                w_next    = bus.flush_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                w_stall_c = 1'b1;
                // A flush coinciding with ready has nothing left to drain
                if (bus.flush_i) begin
                    w_next = bus.div_ready_i ? S_IDLE : S_DRAIN;
                end else if (bus.div_ready_i) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_result_valid_c = ~bus.flush_i;
                w_next           = S_IDLE;
            end
            S_DRAIN: begin
                w_stall_c = bus.req_valid_i;
                if (bus.div_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands latch only on acceptance, so they hold steady through START and WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_rem     <= 1'b0;
            r_op_word    <= 1'b0;
            r_div_start  <= 1'b0;
            r_div_signed <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_result     <= '0;
        end else begin
            r_div_start <= (r_state == S_IDLE) && w_accept && !w_fast;
            if ((r_state == S_IDLE) && w_accept) begin
                r_op_rem     <= bus.req_op_i[0];
                r_op_word    <= bus.req_op_i[2];
                r_div_signed <= ~bus.req_op_i[1];
                r_div_a      <= w_prep_a;
                r_div_b      <= w_prep_b;
                if (w_fast) begin
                    r_result <= w_fast_res;
                end
            end else if ((r_state == S_WAIT) && bus.div_ready_i && !bus.flush_i) begin
                r_result <= fit_width(r_op_word, r_op_rem ? bus.div_r_i : bus.div_q_i);
            end
        end
    end

    assign bus.stall_o        = w_stall_c & rst_n;
    assign bus.result_valid_o = w_result_valid_c;
    assign bus.result_o       = r_result;
    assign bus.div_start_o    = r_div_start;
    assign bus.div_signed_o   = r_div_signed;
    assign bus.div_a_o        = r_div_a;
    assign bus.div_b_o        = r_div_b;
endmodule
